// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: default widths and FSM encoding.
package sram_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LINE_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of both requester ports and the downstream SRAM-controller port.
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LINE_W = DEF_LINE_W
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [LINE_W-1:0] p0_rdata;
    logic              p0_stall;
    logic              p0_done;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [LINE_W-1:0] p1_rdata;
    logic              p1_stall;
    logic              p1_done;

    logic              sram_wr_en;
    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [LINE_W-1:0] sram_rdata;
    logic              sram_pause;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_rdata, p0_stall, p0_done,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_rdata, p1_stall, p1_done,
        output sram_wr_en, sram_rd_en, sram_addr, sram_wdata,
        input  sram_rdata, sram_pause
    );

    // Requesters plus SRAM controller side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_rdata, p0_stall, p0_done,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_rdata, p1_stall, p1_done,
        input  sram_wr_en, sram_rd_en, sram_addr, sram_wdata,
        output sram_rdata, sram_pause
    );

endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin decision: a lone request wins, a tie goes to the port not served last.
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    // Grant index and request-present flag
    always_comb begin
        valid = req0 | req1;
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between two requesters, one transaction in flight at a time.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LINE_W = DEF_LINE_W
)
(
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata0_q, rdata1_q;

    logic arb_grant, arb_valid;
    logic done, rd_en, wr_en;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.p0_req),
        .req1       (bus.p1_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, SRAM enables and completion strobe
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rd_en = ~we_q;
                wr_en = we_q;
                if (!bus.sram_pause) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Latch the granted port's transaction when leaving IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (state_q == IDLE && arb_valid) begin
            last_grant_q <= arb_grant;
            grant_q      <= arb_grant;
            we_q         <= arb_grant ? bus.p1_we    : bus.p0_we;
            addr_q       <= arb_grant ? bus.p1_addr  : bus.p0_addr;
            wdata_q      <= arb_grant ? bus.p1_wdata : bus.p0_wdata;
        end
    end

    // Capture the read line for the owning port on a completed read
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (done && !we_q) begin
            if (grant_q) begin
                rdata1_q <= bus.sram_rdata;
            end else begin
                rdata0_q <= bus.sram_rdata;
            end
        end
    end

    assign bus.sram_rd_en = rd_en;
    assign bus.sram_wr_en = wr_en;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;

    assign bus.p0_done  = done & ~grant_q;
    assign bus.p1_done  = done & grant_q;
    assign bus.p0_stall = bus.p0_req & ~bus.p0_done;
    assign bus.p1_stall = bus.p1_req & ~bus.p1_done;
    assign bus.p0_rdata = rdata0_q;
    assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios, then random traffic vs a reference model.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned LW = DEF_LINE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Standard controller: pause drops on the 6th consecutive enabled cycle
    int unsigned ctl_cnt = 0;
    always @(posedge clk) begin
        if (rst) ctl_cnt <= 0;
        else if (bus.sram_rd_en || bus.sram_wr_en) ctl_cnt <= (ctl_cnt == 5) ? 0 : ctl_cnt + 1;
        else ctl_cnt <= 0;
    end
    assign bus.sram_pause = (ctl_cnt != 5);

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level view (who owns the SRAM, how long it has run)
    bit          m_busy;
    bit          m_owner;
    bit          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int          m_cnt;
    bit          m_last;
    logic [LW-1:0] m_rdata [2];

    // Per-scenario observations
    int rd_cycles, wr_cycles, low_cycles, stall1_cnt, cyc_idx;
    int done_cnt [2];
    int done_at  [2];
    bit done_now [2];
    int order_q [$];

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_cnt = 0; m_last = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic reset_counters();
        rd_cycles = 0; wr_cycles = 0; low_cycles = 0; stall1_cnt = 0; cyc_idx = 0;
        done_cnt[0] = 0; done_cnt[1] = 0; done_at[0] = -1; done_at[1] = -1;
        done_now[0] = 1'b0; done_now[1] = 1'b0;
        order_q.delete();
    endtask

    task automatic drive(input int n, input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (n == 0) begin
            bus.p0_req = r; bus.p0_we = w; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = r; bus.p1_we = w; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge
    task automatic cycle();
        bit exp_done;
        bit r0, r1;
        #1;
        exp_done = m_busy && (m_cnt == 5);
        check1("rd_en", bus.sram_rd_en, m_busy && !m_we);
        check1("wr_en", bus.sram_wr_en, m_busy && m_we);
        if (m_busy) begin
            check64("sram_addr", 64'(bus.sram_addr), 64'(m_addr));
            check64("sram_wdata", 64'(bus.sram_wdata), 64'(m_wdata));
        end
        check1("p0_done", bus.p0_done, exp_done && !m_owner);
        check1("p1_done", bus.p1_done, exp_done && m_owner);
        check1("p0_stall", bus.p0_stall, bus.p0_req && !(exp_done && !m_owner));
        check1("p1_stall", bus.p1_stall, bus.p1_req && !(exp_done && m_owner));
        check64("p0_rdata", bus.p0_rdata, m_rdata[0]);
        check64("p1_rdata", bus.p1_rdata, m_rdata[1]);
        done_now[0] = bus.p0_done;
        done_now[1] = bus.p1_done;
        for (int n = 0; n < 2; n++) begin
            if (done_now[n]) begin
                done_cnt[n]++; done_at[n] = cyc_idx; order_q.push_back(n);
            end
        end
        if (bus.sram_rd_en) rd_cycles++;
        if (bus.sram_wr_en) wr_cycles++;
        if (!bus.sram_rd_en && !bus.sram_wr_en) low_cycles++;
        if (bus.p1_stall) stall1_cnt++;
        r0 = bus.p0_req;
        r1 = bus.p1_req;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (exp_done) begin
                m_busy = 1'b0;
                if (!m_we) m_rdata[m_owner] = bus.sram_rdata;
            end else begin
                m_cnt++;
            end
        end else if (r0 || r1) begin
            m_owner = (r0 && r1) ? !m_last : r1;
            m_last  = m_owner;
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_we    = m_owner ? bus.p1_we    : bus.p0_we;
            m_addr  = m_owner ? bus.p1_addr  : bus.p0_addr;
            m_wdata = m_owner ? bus.p1_wdata : bus.p0_wdata;
        end
        cyc_idx++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input int n, input int budget);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!done_now[n] && k < budget);
        check1("done_within_budget", done_now[n], 1'b1);
    endtask

    task automatic rand_port(input int n);
        bit r = (n == 0) ? bus.p0_req : bus.p1_req;
        if (done_now[n]) begin
            if ($urandom_range(0, 1) == 1) drive(n, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            else drive(n, 1'b0, 1'b0, '0, '0);
        end else if (!r) begin
            if ($urandom_range(0, 2) == 0) drive(n, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if (m_busy && int'(m_owner) == n && $urandom_range(0, 19) == 0) begin
            drive(n, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] line;
        int k;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        bus.sram_rdata = '0;
        model_reset();
        reset_counters();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        cycle();
        check64("rst_addr", 64'(bus.sram_addr), 64'h0);
        check64("rst_wdata", 64'(bus.sram_wdata), 64'h0);
        rst = 1'b0;

        // Single read on p0
        reset_counters();
        bus.sram_rdata = 64'h1122334455667788;
        drive(0, 1'b1, 1'b0, 32'h40, '0);
        run_until_done(0, 20);
        check_int("read_done_idx", done_at[0], 6);
        drive(0, 1'b0, 1'b0, '0, '0);
        cycle();
        check_int("read_rd_cycles", rd_cycles, 6);
        check_int("read_wr_cycles", wr_cycles, 0);
        check_int("read_done_cnt", done_cnt[0], 1);
        check64("read_p0_rdata", bus.p0_rdata, 64'h1122334455667788);
        check64("read_p1_rdata", bus.p1_rdata, 64'h0);

        // Single write on p1
        reset_counters();
        bus.sram_rdata = {$urandom, $urandom};
        drive(1, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
        run_until_done(1, 20);
        check_int("write_done_idx", done_at[1], 6);
        drive(1, 1'b0, 1'b0, '0, '0);
        cycle();
        check_int("write_wr_cycles", wr_cycles, 6);
        check_int("write_rd_cycles", rd_cycles, 0);
        check_int("write_done_cnt", done_cnt[1], 1);
        check64("write_p1_rdata", bus.p1_rdata, 64'h0);
        check64("write_p0_rdata", bus.p0_rdata, 64'h1122334455667788);

        // Tie right after reset: p0 first, p1 at edge 7
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        reset_counters();
        drive(0, 1'b1, 1'b0, 32'h100, '0);
        drive(1, 1'b1, 1'b0, 32'h200, '0);
        for (int j = 0; j < 15; j++) begin
            if (done_now[0]) drive(0, 1'b0, 1'b0, '0, '0);
            if (done_now[1]) drive(1, 1'b0, 1'b0, '0, '0);
            bus.sram_rdata = {$urandom, $urandom};
            cycle();
        end
        check_int("tie_p0_done_idx", done_at[0], 6);
        check_int("tie_p1_done_idx", done_at[1], 13);
        check_int("tie_p1_stall_cycles", stall1_cnt, 13);

        // Continuous contention: alternating grants, one idle cycle between
        reset_counters();
        drive(0, 1'b1, 1'b0, 32'h300, '0);
        drive(1, 1'b1, 1'b1, 32'h400, 32'hCAFEF00D);
        bus.sram_rdata = 64'hA5A5_0000_5A5A_FFFF;
        k = 0;
        while (order_q.size() < 4 && k < 40) begin
            cycle();
            k++;
        end
        check_int("cont_txn_cnt", order_q.size(), 4);
        check_int("cont_order0", order_q[0], 0);
        check_int("cont_order1", order_q[1], 1);
        check_int("cont_order2", order_q[2], 0);
        check_int("cont_order3", order_q[3], 1);
        check_int("cont_last_done_idx", cyc_idx - 1, 27);
        check_int("cont_low_cycles", low_cycles, 4);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        cycle();
        check64("cont_p0_rdata", bus.p0_rdata, 64'hA5A5_0000_5A5A_FFFF);

        // Abort by reset in the 3rd BUSY cycle of a p0 read
        reset_counters();
        drive(0, 1'b1, 1'b0, 32'h80, '0);
        repeat (3) cycle();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        cycle();
        rst = 1'b0;
        cycle();
        check_int("abort_done_cnt", done_cnt[0], 0);
        check_int("abort_rd_cycles", rd_cycles, 3);
        check64("abort_p0_rdata", bus.p0_rdata, 64'h0);

        // Dropped request in the 2nd BUSY cycle still completes
        reset_counters();
        line = {$urandom, $urandom};
        bus.sram_rdata = line;
        drive(0, 1'b1, 1'b0, 32'hC0, '0);
        repeat (2) cycle();
        drive(0, 1'b0, 1'b0, '0, '0);
        run_until_done(0, 20);
        check_int("drop_done_idx", done_at[0], 6);
        cycle();
        check_int("drop_rd_cycles", rd_cycles, 6);
        check_int("drop_done_cnt", done_cnt[0], 1);
        check64("drop_p0_rdata", bus.p0_rdata, line);

        // Next tie after a p0 grant goes to p1
        reset_counters();
        drive(0, 1'b1, 1'b1, 32'h10, 32'h1234);
        drive(1, 1'b1, 1'b1, 32'h20, 32'h5678);
        run_until_done(1, 20);
        check_int("after_drop_first", order_q[0], 1);
        drive(1, 1'b0, 1'b0, '0, '0);
        run_until_done(0, 20);
        drive(0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Random traffic against the model
        reset_counters();
        for (int i = 0; i < 400; i++) begin
            rand_port(0);
            rand_port(1);
            bus.sram_rdata = {$urandom, $urandom};
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
